// File: rtl/mips_cpu_run_pkg.sv
// Shared types for the MIPS CPU run controller.
// States, fault codes and the per-state output flags.
package mips_cpu_run_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RESET,
    ST_WAIT_ACTIVE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE,
    ST_FAULT
  } run_state_t;

  typedef enum logic [1:0] {
    FAULT_NONE     = 2'd0,
    FAULT_NO_START = 2'd1,
    FAULT_TIMEOUT  = 2'd2
  } fault_code_t;

  typedef struct packed {
    logic busy;
    logic done;
    logic fault;
    logic cpu_reset;
    logic cpu_clk_enable;
  } run_flags_t;

  function automatic logic can_start(run_state_t s);
    return (s == ST_IDLE) || (s == ST_DONE) || (s == ST_FAULT);
  endfunction

  function automatic logic trace_open(run_state_t s);
    return (s == ST_RUN) || (s == ST_DRAIN);
  endfunction

  function automatic run_flags_t state_flags(run_state_t s);
    run_flags_t f;
    f = '0;
    f.cpu_reset = 1'b1;
    unique case (s)
      ST_IDLE: ;
      ST_RESET: begin
        f.busy           = 1'b1;
        f.cpu_clk_enable = 1'b1;
      end
      ST_WAIT_ACTIVE, ST_RUN, ST_DRAIN: begin
        f.busy           = 1'b1;
        f.cpu_reset      = 1'b0;
        f.cpu_clk_enable = 1'b1;
      end
      ST_DONE:  f.done  = 1'b1;
      ST_FAULT: f.fault = 1'b1;
      default: ;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/mips_cpu_run_trace_fifo.sv
// Write-back trace buffer: circular FIFO, first-word fall-through,
// extra pointer bit for full/empty, sticky drop flag.
module mips_cpu_run_trace_fifo #(
  parameter int unsigned DEPTH = 16,
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o,
  output logic             overflow_o
);

  localparam int unsigned AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic             empty_q, full_q, ovf_q;
  logic             do_rd, do_wr;

  always_comb begin
    do_rd    = rd_en_i && !empty_q;
    // a pop at full frees the slot the concurrent push needs
    do_wr    = wr_en_i && (!full_q || do_rd);
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_rd};
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_wr};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      empty_q  <= 1'b1;
      full_q   <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      empty_q  <= (wr_ptr_d == rd_ptr_d);
      full_q   <= (wr_ptr_d[AW] != rd_ptr_d[AW]) &&
                  (wr_ptr_d[AW-1:0] == rd_ptr_d[AW-1:0]);
      if (wr_en_i && !do_wr) ovf_q <= 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_wr) mem_q[wr_ptr_q[AW-1:0]] <= wr_data_i;
  end

  assign rd_data_o  = mem_q[rd_ptr_q[AW-1:0]];
  assign empty_o    = empty_q;
  assign full_o     = full_q;
  assign overflow_o = ovf_q;

endmodule

// File: rtl/mips_cpu_run_ctrl.sv
// Run controller for mips_cpu_harvard: reset sequencing, start check,
// cycle timeout, v0 capture on halt and write-back trace.
module mips_cpu_run_ctrl
  import mips_cpu_run_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 100,
  parameter int unsigned RESET_CYCLES   = 1,
  parameter int unsigned TRACE_DEPTH    = 16,
  parameter int unsigned TRACE_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   cpu_reset,
  output logic                   cpu_clk_enable,
  input  logic                   cpu_active,
  input  logic [31:0]            cpu_register_v0,
  input  logic                   wb_valid,
  input  logic [TRACE_WIDTH-1:0] wb_data,
  output logic                   busy,
  output logic                   done,
  output logic                   fault,
  output logic [1:0]             fault_code,
  output logic [31:0]            result,
  output logic [31:0]            cycle_count,
  input  logic                   trace_rd_en,
  output logic [TRACE_WIDTH-1:0] trace_data,
  output logic                   trace_empty,
  output logic                   trace_full,
  output logic                   trace_overflow
);

  localparam int unsigned RCW =
    (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
  localparam logic [RCW-1:0] RST_LAST = RCW'(RESET_CYCLES - 1);
  localparam logic [31:0]    TMO_LAST = 32'(TIMEOUT_CYCLES - 1);

  run_state_t  state_q, state_d;
  logic [RCW-1:0] rcnt_q, rcnt_d;
  logic [31:0] cyc_q, cyc_d;
  logic [31:0] res_q, res_d;
  fault_code_t code_q, code_d;
  run_flags_t  flags_q;
  logic        trace_clr;
  logic        trace_wr;

  always_comb begin
    state_d   = state_q;
    rcnt_d    = rcnt_q;
    cyc_d     = cyc_q;
    res_d     = res_q;
    code_d    = code_q;
    trace_clr = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE, ST_FAULT: begin
        if (start) begin
          state_d   = ST_RESET;
          rcnt_d    = '0;
          cyc_d     = '0;
          res_d     = '0;
          code_d    = FAULT_NONE;
          trace_clr = 1'b1;
        end
      end
      ST_RESET: begin
        if (rcnt_q == RST_LAST) state_d = ST_WAIT_ACTIVE;
        else rcnt_d = rcnt_q + 1'b1;
      end
      ST_WAIT_ACTIVE: begin
        if (cpu_active) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_FAULT;
          code_d  = FAULT_NO_START;
        end
      end
      ST_RUN: begin
        cyc_d = cyc_q + 32'd1;
        // a halt seen on the last allowed cycle still wins
        if (!cpu_active) begin
          state_d = ST_DRAIN;
        end else if (cyc_q == TMO_LAST) begin
          state_d = ST_FAULT;
          code_d  = FAULT_TIMEOUT;
        end
      end
      ST_DRAIN: begin
        res_d   = cpu_register_v0;
        state_d = ST_DONE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign trace_wr = wb_valid && trace_open(state_q);

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      rcnt_q  <= '0;
      cyc_q   <= '0;
      res_q   <= '0;
      code_q  <= FAULT_NONE;
      flags_q <= state_flags(ST_IDLE);
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      cyc_q   <= cyc_d;
      res_q   <= res_d;
      code_q  <= code_d;
      flags_q <= state_flags(state_d);
    end
  end

  mips_cpu_run_trace_fifo #(
    .DEPTH (TRACE_DEPTH),
    .WIDTH (TRACE_WIDTH)
  ) u_trace (
    .clk_i      (clk),
    .rst_ni     (reset),
    .clear_i    (trace_clr),
    .wr_en_i    (trace_wr),
    .wr_data_i  (wb_data),
    .rd_en_i    (trace_rd_en),
    .rd_data_o  (trace_data),
    .empty_o    (trace_empty),
    .full_o     (trace_full),
    .overflow_o (trace_overflow)
  );

  assign busy           = flags_q.busy;
  assign done           = flags_q.done;
  assign fault          = flags_q.fault;
  assign cpu_reset      = flags_q.cpu_reset;
  assign cpu_clk_enable = flags_q.cpu_clk_enable;
  assign fault_code     = code_q;
  assign result         = res_q;
  assign cycle_count    = cyc_q;

endmodule

// File: tb/tb_mips_cpu_run_ctrl.sv
// Bench for mips_cpu_run_ctrl: table of runs, trace scoreboard,
// plus reset and mid-run abort sequences.
module tb_mips_cpu_run_ctrl;

  localparam int TMO = 10;
  localparam int DEP = 8;

  logic        clk = 1'b0;
  logic        reset, start;
  logic        cpu_reset, cpu_clk_enable;
  logic        cpu_active;
  logic [31:0] cpu_register_v0;
  logic        wb_valid;
  logic [31:0] wb_data;
  logic        busy, done, fault;
  logic [1:0]  fault_code;
  logic [31:0] result, cycle_count;
  logic        trace_rd_en;
  logic [31:0] trace_data;
  logic        trace_empty, trace_full, trace_overflow;

  mips_cpu_run_ctrl #(
    .TIMEOUT_CYCLES (TMO),
    .RESET_CYCLES   (1),
    .TRACE_DEPTH    (DEP),
    .TRACE_WIDTH    (32)
  ) dut (
    .clk             (clk),
    .reset           (reset),
    .start           (start),
    .cpu_reset       (cpu_reset),
    .cpu_clk_enable  (cpu_clk_enable),
    .cpu_active      (cpu_active),
    .cpu_register_v0 (cpu_register_v0),
    .wb_valid        (wb_valid),
    .wb_data         (wb_data),
    .busy            (busy),
    .done            (done),
    .fault           (fault),
    .fault_code      (fault_code),
    .result          (result),
    .cycle_count     (cycle_count),
    .trace_rd_en     (trace_rd_en),
    .trace_data      (trace_data),
    .trace_empty     (trace_empty),
    .trace_full      (trace_full),
    .trace_overflow  (trace_overflow)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          no_start;
    int          drop;
    int          nwr;
    int          pop_at;
    logic [31:0] v0;
    bit          exp_done;
    logic [1:0]  exp_code;
    logic [31:0] exp_cnt;
    logic [31:0] exp_res;
  } vec_t;

  vec_t        vecs [7];
  logic [31:0] sb [$];
  bit          ovf_m;
  int          checks = 0;
  int          errors = 0;
  int          cur = 0;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL v%0d %s got %0h want %0h", cur, nm, act, exp);
    end
  endtask

  task automatic chk_idle_reset();
    chk("rst busy", busy, 0);
    chk("rst done", done, 0);
    chk("rst fault", fault, 0);
    chk("rst code", fault_code, 0);
    chk("rst cpu_reset", cpu_reset, 1);
    chk("rst clk_en", cpu_clk_enable, 0);
    chk("rst result", result, 0);
    chk("rst cnt", cycle_count, 0);
    chk("rst empty", trace_empty, 1);
    chk("rst full", trace_full, 0);
    chk("rst ovf", trace_overflow, 0);
  endtask

  task automatic run_vec(input vec_t v);
    bit halted;
    cpu_register_v0 = v.v0;
    cpu_active = !v.no_start;
    start = 1'b1;
    tick();
    start = 1'b0;
    sb.delete();
    ovf_m = 1'b0;
    chk("reset busy", busy, 1);
    chk("reset cpu_reset", cpu_reset, 1);
    chk("reset clk_en", cpu_clk_enable, 1);
    chk("start clr empty", trace_empty, 1);
    chk("start clr cnt", cycle_count, 0);
    tick();
    chk("wait cpu_reset", cpu_reset, 0);
    chk("wait clk_en", cpu_clk_enable, 1);
    tick();
    if (!v.no_start) begin
      chk("run busy", busy, 1);
      halted = 1'b0;
      for (int k = 1; k <= TMO && !halted; k++) begin
        if (k == v.drop) cpu_active = 1'b0;
        if (k == v.pop_at && sb.size() > 0) begin
          chk("pop at full", trace_data, sb[0]);
          trace_rd_en = 1'b1;
          void'(sb.pop_front());
        end
        if (k <= v.nwr) begin
          wb_valid = 1'b1;
          wb_data  = 32'(k);
          if (sb.size() < DEP) sb.push_back(32'(k));
          else ovf_m = 1'b1;
        end
        tick();
        wb_valid    = 1'b0;
        trace_rd_en = 1'b0;
        if (k == v.drop) halted = 1'b1;
      end
      if (halted) begin
        chk("drain done", done, 0);
        chk("drain busy", busy, 1);
        tick();
      end
    end
    wb_valid = 1'b1;
    wb_data  = 32'hFFFF_FFFF;
    tick();
    wb_valid = 1'b0;
    chk("end done", done, v.exp_done);
    chk("end fault", fault, !v.exp_done);
    chk("end code", fault_code, v.exp_code);
    chk("end cnt", cycle_count, v.exp_cnt);
    chk("end result", result, v.exp_res);
    chk("end busy", busy, 0);
    chk("end cpu_reset", cpu_reset, 1);
    chk("end clk_en", cpu_clk_enable, 0);
    chk("end ovf", trace_overflow, ovf_m);
    chk("end full", trace_full, sb.size() == DEP);
    for (int i = 0; i < DEP && sb.size() > 0; i++) begin
      chk("trace empty", trace_empty, 0);
      chk("trace data", trace_data, sb[0]);
      trace_rd_en = 1'b1;
      tick();
      trace_rd_en = 1'b0;
      void'(sb.pop_front());
    end
    chk("trace drained", trace_empty, 1);
    trace_rd_en = 1'b1;
    tick();
    trace_rd_en = 1'b0;
    chk("pop on empty", trace_empty, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 7, 5, 0, 32'h1234, 1'b1, 2'd0, 32'd7, 32'h1234};
    vecs[1] = '{1'b1, 0, 0, 0, 32'hDEAD, 1'b0, 2'd1, 32'd0, 32'h0};
    vecs[2] = '{1'b0, 0, 3, 0, 32'hBEEF, 1'b0, 2'd2, 32'd10, 32'h0};
    vecs[3] = '{1'b0, 10, 2, 0, 32'h55AA, 1'b1, 2'd0, 32'd10, 32'h55AA};
    vecs[4] = '{1'b0, 10, 10, 0, 32'h77, 1'b1, 2'd0, 32'd10, 32'h77};
    vecs[5] = '{1'b0, 0, 9, 9, 32'h0, 1'b0, 2'd2, 32'd10, 32'h0};
    vecs[6] = '{1'b0, 1, 1, 0, 32'hCAFE, 1'b1, 2'd0, 32'd1, 32'hCAFE};

    reset = 1'b0;
    start = 1'b0;
    cpu_active = 1'b0;
    cpu_register_v0 = '0;
    wb_valid = 1'b0;
    wb_data = '0;
    trace_rd_en = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    chk_idle_reset();
    tick();
    chk("idle hold busy", busy, 0);

    for (int i = 0; i < 7; i++) begin
      cur = i;
      run_vec(vecs[i]);
    end

    cur = 100;
    cpu_active = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    wb_valid = 1'b1;
    wb_data  = 32'h99;
    tick();
    wb_valid = 1'b0;
    chk("mid run empty", trace_empty, 0);
    chk("mid run cnt", cycle_count, 1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    chk_idle_reset();
    tick();
    chk("post abort idle", busy, 0);
    cur = 101;
    run_vec(vecs[0]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
